// File: rtl/ccl_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ccl_fetch_ctrl_if
//  Purpose  : Bundles the fetch controller's start request, frame-memory read
//             port, byte-buffer write port and group handshake.
//             - master : the fetch controller.
//             - slave  : the surrounding DCU logic (memory, buffer, consumer).
//  Revision : 1.0 - initial release
// ============================================================================
interface ccl_fetch_ctrl_if #(
   parameter int ADDR_W   = 10,
   parameter int N_GROUPS = 48
);
   localparam int IDX_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

   // Frame request
   logic              start;
   logic [ADDR_W-1:0] base_addr;

   // Frame-memory read port
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;

   // Byte-buffer write port
   logic              buf_enb;
   logic [1:0]        buf_addr;
   logic [7:0]        buf_byte;

   // Group handshake and status
   logic              grp_valid;
   logic              grp_ready;
   logic [IDX_W-1:0]  grp_idx;
   logic              busy;
   logic              done;

   modport master (
      input  start, base_addr, mem_data, grp_ready,
      output mem_rd, mem_addr, buf_enb, buf_addr, buf_byte,
             grp_valid, grp_idx, busy, done
   );

   modport slave (
      output start, base_addr, mem_data, grp_ready,
      input  mem_rd, mem_addr, buf_enb, buf_addr, buf_byte,
             grp_valid, grp_idx, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/ccl_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ccl_fetch_ctrl
//  Purpose  : Loads the CCL 4-byte square buffer from byte-wide frame memory,
//             one group at a time, then holds the buffer and offers the group
//             to the square consumer over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module ccl_fetch_ctrl #(
   parameter int ADDR_W   = 10,
   parameter int N_GROUPS = 48
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ccl_fetch_ctrl_if.master        bus
);

   localparam int IDX_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_GROUPS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WRITE = 3'd2,
      S_VALID = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_q;

   // Address counter: always the next byte address to be read.
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   // Slot of the read issued in the current cycle.
   logic [1:0]        slot_q;
   logic [1:0]        slot_d;
   logic [IDX_W-1:0]  grp_idx_q;

   // Registered outputs
   logic              mem_rd_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              buf_enb_q;
   logic [1:0]        buf_addr_q;
   logic              grp_valid_q;
   logic              busy_q;
   logic              done_q;

   // Incremented counter/slot values; address arithmetic wraps modulo 2^ADDR_W.
   always_comb begin
      addr_d = addr_q + ADDR_W'(1);
      slot_d = slot_q + 2'd1;
   end

   // Fetch sequencer: state, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         slot_q      <= 2'd0;
         grp_idx_q   <= '0;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= '0;
         buf_enb_q   <= 1'b0;   // drops any read still in flight
         buf_addr_q  <= 2'd0;
         grp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // Buffer writes trail the read strobe by one cycle to meet mem_data.
         buf_enb_q  <= mem_rd_q;
         buf_addr_q <= slot_q;
         done_q     <= 1'b0;

         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q    <= S_FETCH;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= bus.base_addr;
                  addr_q     <= bus.base_addr + ADDR_W'(1);
                  slot_q     <= 2'd0;
                  grp_idx_q  <= '0;
                  busy_q     <= 1'b1;
               end
            end

            S_FETCH: begin
               if (slot_q == 2'd3) begin
                  // Last read of the group was issued this cycle.
                  state_q  <= S_WRITE;
                  mem_rd_q <= 1'b0;
                  slot_q   <= 2'd0;
               end else begin
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= addr_q;
                  addr_q     <= addr_d;
                  slot_q     <= slot_d;
               end
            end

            S_WRITE: begin
               // Slot-3 byte lands in the buffer this cycle.
               state_q     <= S_VALID;
               grp_valid_q <= 1'b1;
            end

            S_VALID: begin
               if (bus.grp_ready) begin
                  grp_valid_q <= 1'b0;
                  if (grp_idx_q == LAST_IDX) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= S_FETCH;
                     grp_idx_q  <= grp_idx_q + IDX_W'(1);
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= addr_q;
                     addr_q     <= addr_d;
                     slot_q     <= 2'd0;
                  end
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q     <= S_IDLE;
               mem_rd_q    <= 1'b0;
               grp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_rd    = mem_rd_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.buf_enb   = buf_enb_q;
   assign bus.buf_addr  = buf_addr_q;
   assign bus.buf_byte  = bus.mem_data;   // memory data goes straight to the buffer
   assign bus.grp_valid = grp_valid_q;
   assign bus.grp_idx   = grp_idx_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: doc/ccl_fetch_ctrl.md
# ccl_fetch_ctrl

Sequencer that loads the CCL 4-byte square buffer from byte-wide frame memory, one 4-byte group at a time. It drives the buffer's write enable, slot address and byte lines. After each group is complete it holds the buffer stable and raises a valid/ready handshake toward the square consumer. It sits in the DCU between the frame-memory read port and the CCL byte buffer, and walks N_GROUPS groups per start pulse.

## Interface
- ADDR_W, 10: frame-memory byte address width.
- N_GROUPS, 48: groups (4 bytes / 10 squares each) fetched per frame; legal range 1..2^(ADDR_W-2).
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  frame fetch request; sampled only in IDLE.
- base_addr  in  ADDR_W  first byte address; latched when start is accepted.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory byte address.
- mem_data  in  8  read data, valid exactly 1 cycle after mem_rd.
- buf_enb  out  1  byte-buffer write enable.
- buf_addr  out  2  byte-buffer slot (0..3).
- buf_byte  out  8  byte to buffer; wired straight from mem_data.
- grp_valid  out  1  buffer holds a complete group.
- grp_ready  in  1  consumer accepts the current group.
- grp_idx  out  clog2(N_GROUPS)  index of the group being fetched or held.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last group is accepted.

## Operation
- States: IDLE, FETCH, WRITE, VALID, DONE.
- IDLE → FETCH on start=1. On the same edge: latch base_addr into the address counter, clear slot to 0, clear grp_idx to 0.
- FETCH, 4 cycles:
  - mem_rd=1, mem_addr = counter, slot = 0,1,2,3.
  - Counter increments every cycle.
  - Slot wraps 3→0 and the state goes to WRITE.
- buf_enb and buf_addr are registered copies of mem_rd and slot, delayed 1 cycle. They therefore align with mem_data.
- WRITE, 1 cycle: carries the slot-3 buffer write. mem_rd=0. Next state is VALID.
- VALID:
  - grp_valid=1; no buffer writes.
  - On grp_ready=1: if grp_idx = N_GROUPS-1 go to DONE, otherwise increment grp_idx and go to FETCH.
  - With grp_ready=0, stay indefinitely.
- DONE, 1 cycle: done=1, then IDLE.
- Address arithmetic is modulo 2^ADDR_W: base_addr + 4·grp_idx + slot. Crossing the top of memory wraps to 0 with no error.
- start in any state other than IDLE is ignored; it is not queued.
- Reset in any state, including mid-FETCH:
  - Next state is IDLE.
  - All outputs return to reset values.
  - An in-flight memory read is discarded (buf_enb forced 0).
- Reset values: mem_rd 0, mem_addr 0, buf_enb 0, buf_addr 0, grp_valid 0, grp_idx 0, busy 0, done 0.
- grp_valid, busy and done are Moore outputs; none is combinationally dependent on grp_ready or start.

## Timing
- start accepted at edge E0. FETCH occupies cycles 1–4, WRITE cycle 5, VALID from cycle 6.
- start-to-grp_valid latency is 6 cycles. The buffer's 30-bit square output is stable whenever grp_valid=1.
- buf_enb is high in cycles 2–5 with buf_addr 0,1,2,3.
- Per-group period is 6 cycles with grp_ready tied high: 4 FETCH + 1 WRITE + 1 VALID. Frame time is 6·N_GROUPS + 1 (DONE) cycles.
- grp_ready seen high in VALID gives mem_rd=1 in the very next cycle.
- Memory contract: mem_data must be presented exactly 1 cycle after mem_rd. No wait states are supported.

## Test plan
- N_GROUPS=2, base_addr=0x010, memory byte[a]=a[7:0], grp_ready=1:
  - mem_addr sequence 0x010–0x013, then 0x014–0x017.
  - buf_byte/buf_addr pairs (0x10,0)…(0x13,3).
  - grp_valid in cycles 6 and 12; done in cycle 13.
- Backpressure: grp_ready=0 for 10 cycles in the first VALID.
  - grp_valid stays high; mem_rd and buf_enb stay 0; buffer contents are unchanged.
  - The next FETCH starts 1 cycle after grp_ready rises.
- Wrap: ADDR_W=10, base_addr=0x3FE, N_GROUPS=1 → mem_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- start pulsed in FETCH and in VALID → ignored: grp_idx and address sequence unchanged, exactly one done per frame.
- rst_n=0 for 1 cycle in the 3rd FETCH cycle:
  - Next cycle all outputs are at reset values; buf_enb=0 even though a read was in flight.
  - A subsequent start fetches from the newly latched base_addr.
- Memory bytes 0xFF for group 0 and 0x00 for group 1, with the byte buffer attached → the 30-bit square output is all ones during the first grp_valid and all zeros during the second.
